q9b_seq_checker: RTL

Downstream monitor for the q9b two-bit sequential counter. Samples the counter's `A`/`B` outputs every clock and checks that `{A,B}` advances 00→01→10→11→00 by exactly one step per clock. Locks onto a valid stream, counts full wraps, flags and counts step errors, and latches a fault after repeated misses. Sits on the same clock as q9b, directly on its outputs.

---
 rtl/q9b_seq_checker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/q9b_seq_checker.sv
// ---------------------------------------------------------------------------
// q9b_seq_checker
//
// Purpose:
//   Downstream monitor for the q9b two-bit sequential counter. Every rising
//   edge it samples {A,B} and checks that the value advanced by exactly one
//   step (00->01->10->11->00) since the previous edge. The checker hunts for
//   RESYNC_LEN correct transitions in a row before it trusts the stream.
//   Once locked it counts full wraps and step errors. ERR_LIMIT consecutive
//   errors latch a sticky fault that only clr or reset can leave.
//
// Parameters:
//   CNT_W      - width of wrap_count / err_count (both saturate)
//   RESYNC_LEN - consecutive correct transitions needed to lock (1..15)
//   ERR_LIMIT  - consecutive misses while locked that force FAULT (1..15)
//
// Ports:
//   clk        in   rising-edge clock shared with q9b
//   reset      in   asynchronous active-high reset, clears everything
//   clr        in   synchronous clear: back to HUNT, counters zeroed
//   A, B       in   q9b outputs (A is the MSB)
//   locked     out  high while in LOCKED
//   fault      out  high while in FAULT
//   err_pulse  out  one-cycle pulse per incorrect transition seen in LOCKED
//   wrap_pulse out  one-cycle pulse per 11->00 transition seen in LOCKED
//   wrap_count out  saturating count of wraps seen in LOCKED
//   err_count  out  saturating count of errors seen in LOCKED
// ---------------------------------------------------------------------------
module q9b_seq_checker #(
  parameter int CNT_W      = 8,
  parameter int RESYNC_LEN = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             A,
  input  logic             B,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [3:0]       RESYNC_L = 4'(RESYNC_LEN);
  localparam logic [3:0]       ERR_L    = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q,     state_d;
  logic [1:0]       prev_q,      prev_d;
  logic             havePrev_q,  havePrev_d;
  logic [3:0]       goodCnt_q,   goodCnt_d;
  logic [3:0]       missCnt_q,   missCnt_d;
  logic [CNT_W-1:0] wrapCnt_q,   wrapCnt_d;
  logic [CNT_W-1:0] errCnt_q,    errCnt_d;
  logic             errPulse_q,  errPulse_d;
  logic             wrapPulse_q, wrapPulse_d;
  logic             locked_q,    locked_d;
  logic             fault_q,     fault_d;

  logic [1:0] sample;
  logic [1:0] expectedNext;
  logic       stepOk;
  logic       isWrap;
  logic [3:0] goodInc;
  logic [3:0] missInc;

  // Transition classification. The 2-bit add wraps 11 back to 00 on its own,
  // which is exactly the "prev + 1 mod 4" rule.
  always_comb begin
    sample       = {A, B};
    expectedNext = prev_q + 2'd1;
    stepOk       = (sample == expectedNext);
    isWrap       = (prev_q == 2'b11) && (sample == 2'b00);
    goodInc      = goodCnt_q + 4'd1;
    missInc      = missCnt_q + 4'd1;
  end

  // Next-state and output decode. Everything defaults to "hold" with pulses
  // low; clr is checked first so it beats whatever transition happens at the
  // same edge. The very first edge after reset/clr only captures prev.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    havePrev_d  = havePrev_q;
    goodCnt_d   = goodCnt_q;
    missCnt_d   = missCnt_q;
    wrapCnt_d   = wrapCnt_q;
    errCnt_d    = errCnt_q;
    errPulse_d  = 1'b0;
    wrapPulse_d = 1'b0;

    if (clr) begin
      state_d    = HUNT;
      prev_d     = sample;
      havePrev_d = 1'b0;
      goodCnt_d  = '0;
      missCnt_d  = '0;
      wrapCnt_d  = '0;
      errCnt_d   = '0;
    end else begin
      // prev tracks the input in every state, FAULT included
      prev_d     = sample;
      havePrev_d = 1'b1;

      if (havePrev_q) begin
        unique case (state_q)
          HUNT: begin
            if (stepOk) begin
              if (goodInc == RESYNC_L) begin
                state_d   = LOCKED;
                goodCnt_d = '0;
              end else begin
                goodCnt_d = goodInc;
              end
            end else begin
              goodCnt_d = '0;
            end
          end

          LOCKED: begin
            if (stepOk) begin
              missCnt_d = '0;
              if (isWrap) begin
                wrapPulse_d = 1'b1;
                if (wrapCnt_q != CNT_MAX) wrapCnt_d = wrapCnt_q + 1'b1;
              end
            end else begin
              errPulse_d = 1'b1;
              if (errCnt_q != CNT_MAX) errCnt_d = errCnt_q + 1'b1;
              missCnt_d = missInc;
              if (missInc == ERR_L) state_d = FAULT;
            end
          end

          FAULT: begin
            // sticky: comparisons ignored, counters frozen
          end

          default: state_d = HUNT;
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  // State and output registers, cleared asynchronously by reset so the
  // outputs drop the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= 2'b00;
      havePrev_q  <= 1'b0;
      goodCnt_q   <= '0;
      missCnt_q   <= '0;
      wrapCnt_q   <= '0;
      errCnt_q    <= '0;
      errPulse_q  <= 1'b0;
      wrapPulse_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      havePrev_q  <= havePrev_d;
      goodCnt_q   <= goodCnt_d;
      missCnt_q   <= missCnt_d;
      wrapCnt_q   <= wrapCnt_d;
      errCnt_q    <= errCnt_d;
      errPulse_q  <= errPulse_d;
      wrapPulse_q <= wrapPulse_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign err_pulse  = errPulse_q;
  assign wrap_pulse = wrapPulse_q;
  assign wrap_count = wrapCnt_q;
  assign err_count  = errCnt_q;

endmodule
